// File: rtl/ov7725_cfg_pkg.sv
// Shared definitions for the OV7725 power-up configuration sequencer.
package ov7725_cfg_pkg;

    typedef enum logic [2:0] {
        WAIT_PWR,
        ISSUE,
        BUSY,
        GAP,
        DONE
    } cfg_state_t;

    localparam int unsigned OV7725_REG_NUM   = 69;
    localparam logic [7:0]  OV7725_SRST_ADDR = 8'h12;
    localparam logic [7:0]  OV7725_SRST_DATA = 8'h80;
    localparam logic [6:0]  OV7725_DEV_ADDR  = 7'h21;
    localparam int unsigned CNT_WAIT_W       = 20;

endpackage

// File: rtl/ov7725_cfg_rom.sv
// OV7725 register table: idx -> {register address, register data}.
module ov7725_cfg_rom
    import ov7725_cfg_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [15:0] rom_data
);

    always_comb begin
        rom_data = 16'hFFFF;
        case (idx)
            8'd0:  rom_data = {OV7725_SRST_ADDR, OV7725_SRST_DATA};
            8'd1:  rom_data = 16'h3D03;  8'd2:  rom_data = 16'h1500;
            8'd3:  rom_data = 16'h1722;  8'd4:  rom_data = 16'h18A4;
            8'd5:  rom_data = 16'h1907;  8'd6:  rom_data = 16'h1AF0;
            8'd7:  rom_data = 16'h3200;  8'd8:  rom_data = 16'h29A0;
            8'd9:  rom_data = 16'h2CF0;  8'd10: rom_data = 16'h2A00;
            8'd11: rom_data = 16'h1101;  8'd12: rom_data = 16'h427F;
            8'd13: rom_data = 16'h4D09;  8'd14: rom_data = 16'h63F0;
            8'd15: rom_data = 16'h64FF;  8'd16: rom_data = 16'h6520;
            8'd17: rom_data = 16'h6600;  8'd18: rom_data = 16'h6700;
            8'd19: rom_data = 16'h695D;  8'd20: rom_data = 16'h13FF;
            8'd21: rom_data = 16'h0D41;  8'd22: rom_data = 16'h0F01;
            8'd23: rom_data = 16'h1406;  8'd24: rom_data = 16'h2475;
            8'd25: rom_data = 16'h2563;  8'd26: rom_data = 16'h26D1;
            8'd27: rom_data = 16'h2BFF;  8'd28: rom_data = 16'h6BAA;
            8'd29: rom_data = 16'h8E10;  8'd30: rom_data = 16'h8F00;
            8'd31: rom_data = 16'h9000;  8'd32: rom_data = 16'h9100;
            8'd33: rom_data = 16'h9200;  8'd34: rom_data = 16'h9300;
            8'd35: rom_data = 16'h942C;  8'd36: rom_data = 16'h9524;
            8'd37: rom_data = 16'h9608;  8'd38: rom_data = 16'h9714;
            8'd39: rom_data = 16'h9824;  8'd40: rom_data = 16'h9938;
            8'd41: rom_data = 16'h9A9E;  8'd42: rom_data = 16'h9B00;
            8'd43: rom_data = 16'h9C40;  8'd44: rom_data = 16'hA740;
            8'd45: rom_data = 16'hA840;  8'd46: rom_data = 16'hA980;
            8'd47: rom_data = 16'hAA80;  8'd48: rom_data = 16'h9E81;
            8'd49: rom_data = 16'hA606;  8'd50: rom_data = 16'h7E0C;
            8'd51: rom_data = 16'h7F16;  8'd52: rom_data = 16'h802A;
            8'd53: rom_data = 16'h814E;  8'd54: rom_data = 16'h8261;
            8'd55: rom_data = 16'h836F;  8'd56: rom_data = 16'h847B;
            8'd57: rom_data = 16'h8586;  8'd58: rom_data = 16'h868E;
            8'd59: rom_data = 16'h8797;  8'd60: rom_data = 16'h88A4;
            8'd61: rom_data = 16'h89AF;  8'd62: rom_data = 16'h8AC5;
            8'd63: rom_data = 16'h8BD7;  8'd64: rom_data = 16'h8CE8;
            8'd65: rom_data = 16'h8D20;  8'd66: rom_data = 16'h3300;
            8'd67: rom_data = 16'h2299;  8'd68: rom_data = 16'h2303;
            default: rom_data = 16'hFFFF;
        endcase
    end

endmodule

// File: rtl/ov7725_cfg.sv
// OV7725 power-up sequencer: waits for power, then issues one SCCB write per
// table entry, with a settle gap after the soft-reset entry.
module ov7725_cfg
    import ov7725_cfg_pkg::*;
#(
    parameter int unsigned REG_NUM    = OV7725_REG_NUM,
    parameter int unsigned PWR_WAIT   = 1_000_000,
    parameter int unsigned SRST_WAIT  = 50_000,
    parameter bit          SRST_FIRST = 1'b1
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i2c_clk,
    input  logic        i2c_end,
    input  logic        cfg_req,
    output logic        i2c_start,
    output logic        wr_en,
    output logic        rd_en,
    output logic        addr_num,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  cfg_idx,
    output logic        cfg_busy,
    output logic        cfg_done
);

    localparam logic [7:0]            LAST_IDX  = 8'(REG_NUM - 1);
    localparam logic [CNT_WAIT_W-1:0] PWR_LAST  = CNT_WAIT_W'(PWR_WAIT - 1);
    localparam logic [CNT_WAIT_W-1:0] SRST_LAST = CNT_WAIT_W'(SRST_WAIT - 1);

    cfg_state_t            state, state_nxt;
    logic [7:0]            idx, idx_nxt;
    logic [CNT_WAIT_W-1:0] cnt_wait, cnt_nxt;
    logic                  start_nxt;
    logic                  i2c_clk_d, i2c_end_d;
    logic                  clk_rise, end_rise;
    logic [15:0]           rom_data;

    assign clk_rise = i2c_clk & ~i2c_clk_d;
    assign end_rise = i2c_end & ~i2c_end_d;

    ov7725_cfg_rom u_rom (
        .idx      (idx),
        .rom_data (rom_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= WAIT_PWR;
            idx       <= '0;
            cnt_wait  <= '0;
            i2c_start <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_busy  <= 1'b0;
            i2c_clk_d <= 1'b0;
            i2c_end_d <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt_wait  <= cnt_nxt;
            i2c_start <= start_nxt;
            cfg_done  <= (state_nxt == DONE);
            cfg_busy  <= (state_nxt != DONE);
            i2c_clk_d <= i2c_clk;
            i2c_end_d <= i2c_end;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt_wait;
        start_nxt = 1'b0;
        case (state)
            WAIT_PWR: begin
                if (cnt_wait == PWR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end else begin
                    cnt_nxt = cnt_wait + 1'b1;
                end
            end
            ISSUE: begin
                if (clk_rise) begin
                    start_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // held from the setting clk_rise to the next one: one i2c_clk period
                start_nxt = i2c_start & ~clk_rise;
                if (end_rise) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else if (SRST_FIRST && idx == 8'd0) begin
                        idx_nxt   = 8'd1;
                        state_nxt = GAP;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = ISSUE;
                    end
                end
            end
            GAP: begin
                if (cnt_wait == SRST_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end else begin
                    cnt_nxt = cnt_wait + 1'b1;
                end
            end
            DONE: begin
                if (cfg_req) begin
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = WAIT_PWR;
        endcase
    end

    assign wr_en     = 1'b1;
    assign rd_en     = 1'b0;
    assign addr_num  = 1'b0;
    assign byte_addr = {8'h00, rom_data[15:8]};
    assign wr_data   = rom_data[7:0];
    assign cfg_idx   = idx;

endmodule

// File: tb/tb_ov7725_cfg.sv
// Directed bench for ov7725_cfg with a small SCCB responder model.
module tb_ov7725_cfg;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        i2c_clk = 1'b0;
    logic        i2c_end = 1'b0;
    logic        cfg_req;
    logic        i2c_start, wr_en, rd_en, addr_num, cfg_busy, cfg_done;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data, cfg_idx;

    int unsigned n_vec = 0, n_bad = 0;
    int unsigned cyc = 0, n_rises = 0, width = 0, rise_cyc = 0, end_cyc = 0;
    logic        prev_start = 1'b0, prev_end = 1'b0;
    logic [15:0] rise_addr;
    logic [7:0]  rise_data, rise_idx;
    int unsigned div = 0, wcnt = 0, hold = 0, end_len = 1;
    bit          pend = 1'b0;

    ov7725_cfg #(
        .REG_NUM    (4),
        .PWR_WAIT   (20),
        .SRST_WAIT  (10),
        .SRST_FIRST (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i2c_clk   (i2c_clk),
        .i2c_end   (i2c_end),
        .cfg_req   (cfg_req),
        .i2c_start (i2c_start),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr_num  (addr_num),
        .byte_addr (byte_addr),
        .wr_data   (wr_data),
        .cfg_idx   (cfg_idx),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    // registered sys_clk/8 divider, as the sccb block produces it
    always @(posedge sys_clk) begin
        if (div == 3) begin
            div = 0;
            i2c_clk <= ~i2c_clk;
        end else begin
            div++;
        end
    end

    // responder: i2c_end rises 40 i2c_clk periods after i2c_start is sampled
    always @(posedge i2c_clk) begin
        if (!sys_rst_n) begin
            pend = 1'b0;
            hold = 0;
            i2c_end <= 1'b0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) i2c_end <= 1'b0;
            end
            if (pend) begin
                wcnt--;
                if (wcnt == 0) begin
                    pend = 1'b0;
                    i2c_end <= 1'b1;
                    hold = end_len;
                end
            end else if (i2c_start) begin
                pend = 1'b1;
                wcnt = 40;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (i2c_start && !prev_start) begin
            n_rises++;
            rise_cyc  = cyc;
            rise_addr = byte_addr;
            rise_data = wr_data;
            rise_idx  = cfg_idx;
            width     = 1;
            chk("start_align", {31'd0, i2c_clk}, 32'd1);
        end else if (i2c_start) begin
            width++;
        end else if (prev_start && sys_rst_n) begin
            chk("start_width", width, 32'd8);
        end
        if (i2c_end && !prev_end) end_cyc = cyc;
        prev_start = i2c_start;
        prev_end   = i2c_end;
    end

    task automatic wait_rise(input string tag, input int budget);
        int unsigned n0;
        int k;
        n0 = n_rises;
        k  = 0;
        while (n_rises == n0 && k < budget) begin
            @(negedge sys_clk); #1;
            k++;
        end
        chk(tag, n_rises - n0, 32'd1);
    endtask

    task automatic wait_idx(input string tag, input logic [7:0] v, input int budget);
        int k;
        k = 0;
        while (cfg_idx !== v && k < budget) begin
            @(negedge sys_clk); #1;
            k++;
        end
        chk(tag, {24'd0, cfg_idx}, {24'd0, v});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (cfg_done !== 1'b1 && k < budget) begin
            @(negedge sys_clk); #1;
            k++;
        end
        chk({tag, "_seen"}, {31'd0, cfg_done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, cfg_busy}, 32'd0);
        chk({tag, "_idx"}, {24'd0, cfg_idx}, 32'd3);
        chk({tag, "_lat"}, cyc - end_cyc, 32'd1);
    endtask

    task automatic pulse_req();
        @(negedge sys_clk); #1;
        cfg_req = 1'b1;
        @(negedge sys_clk); #1;
        cfg_req = 1'b0;
    endtask

    initial begin
        int unsigned rel, e, s0, r;
        int d;
        sys_rst_n = 1'b0;
        cfg_req   = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_start", {31'd0, i2c_start}, 32'd0);
        chk("rst_idx", {24'd0, cfg_idx}, 32'd0);
        chk("rst_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
        chk("const_ports", {29'd0, wr_en, rd_en, addr_num}, 32'b100);
        chk("rom0", {8'd0, byte_addr, wr_data}, 32'h0012_80);

        // power wait and the soft-reset write
        s0 = n_rises;
        sys_rst_n = 1'b1;
        rel = cyc;
        @(negedge sys_clk); #1;
        chk("busy_after_rel", {31'd0, cfg_busy}, 32'd1);
        wait_rise("rise_e0", 60);
        d = int'(rise_cyc - rel);
        chk("pwr_wait_min", {31'd0, d >= 21}, 32'd1);
        chk("pwr_wait_max", {31'd0, d <= 28}, 32'd1);
        chk("e0_addr", {16'd0, rise_addr}, 32'h0012);
        chk("e0_data", {24'd0, rise_data}, 32'h80);

        // settle gap after entry 0, none after entry 1
        wait_idx("idx1", 8'd1, 600);
        e = cyc;
        wait_rise("rise_e1", 40);
        d = int'(rise_cyc - e);
        chk("gap_min", {31'd0, d >= 11}, 32'd1);
        chk("gap_max", {31'd0, d <= 18}, 32'd1);
        chk("e1_entry", {8'd0, rise_addr, rise_data}, 32'h003D_03);
        wait_idx("idx2", 8'd2, 600);
        e = cyc;
        wait_rise("rise_e2", 20);
        chk("no_gap_e2", {31'd0, (rise_cyc - e) <= 8}, 32'd1);
        chk("e2_entry", {8'd0, rise_addr, rise_data}, 32'h0015_00);
        wait_done("done1", 1200);
        chk("starts_run1", n_rises - s0, 32'd4);

        repeat (100) @(negedge sys_clk);
        #1;
        chk("idle_no_start", n_rises - s0, 32'd4);
        chk("idle_done", {31'd0, cfg_done}, 32'd1);

        // re-run on request, with a stray request while busy
        s0 = n_rises;
        @(negedge sys_clk); #1;
        cfg_req = 1'b1;
        r = cyc;
        @(negedge sys_clk); #1;
        cfg_req = 1'b0;
        chk("req_done_clr", {31'd0, cfg_done}, 32'd0);
        wait_rise("rise_req", 20);
        d = int'(rise_cyc - r);
        chk("req_lat_min", {31'd0, d >= 2}, 32'd1);
        chk("req_lat_max", {31'd0, d <= 9}, 32'd1);
        chk("req_idx0", {24'd0, rise_idx}, 32'd0);
        chk("req_entry", {8'd0, rise_addr, rise_data}, 32'h0012_80);
        pulse_req();
        wait_done("done2", 2000);
        chk("starts_run2", n_rises - s0, 32'd4);

        // i2c_end held for 3 periods advances idx once
        end_len = 3;
        s0 = n_rises;
        pulse_req();
        wait_idx("hold_idx_rise", 8'd1, 700);
        r = 0;
        while (i2c_end && r < 60) begin
            @(negedge sys_clk); #1;
            r++;
        end
        chk("hold_end_fell", {31'd0, i2c_end}, 32'd0);
        chk("hold_idx", {24'd0, cfg_idx}, 32'd1);
        wait_done("done3", 2000);
        chk("starts_run3", n_rises - s0, 32'd4);
        end_len = 1;

        // reset during entry 2
        pulse_req();
        wait_idx("rst_mid_idx2", 8'd2, 1200);
        wait_rise("rst_mid_rise", 20);
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_start", {31'd0, i2c_start}, 32'd0);
        chk("rst_mid_idx", {24'd0, cfg_idx}, 32'd0);
        chk("rst_mid_busy", {31'd0, cfg_busy}, 32'd0);
        repeat (10) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        rel = cyc;
        wait_rise("rise_after_rst", 60);
        d = int'(rise_cyc - rel);
        chk("rst_pwr_min", {31'd0, d >= 21}, 32'd1);
        chk("rst_pwr_max", {31'd0, d <= 28}, 32'd1);
        chk("rst_entry", {8'd0, rise_addr, rise_data}, 32'h0012_80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ov7725_cfg.md
Name: ov7725_cfg

Overview:
Power-up configuration sequencer for the OV7725 camera, directly upstream of the sccb master. After a power-on wait it walks a fixed register table and issues one SCCB write per entry. Each write is started with a one-i2c_clk-period i2c_start pulse, and the sequencer waits for i2c_end before moving to the next entry. Entry 0 is the sensor soft reset (0x12 = 0x80) and is followed by a settle gap. cfg_done gates the downstream capture logic.

Parameters:
REG_NUM, 69, number of table entries (1..255)
PWR_WAIT, 1_000_000, sys_clk cycles to wait after reset before the first write (20 ms at 50 MHz)
SRST_WAIT, 50_000, sys_clk cycles to wait after the entry-0 write completes (1 ms)
SRST_FIRST, 1, 1 = apply SRST_WAIT after entry 0; 0 = no gap

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
i2c_clk  in  1  drive clock from sccb; a registered divide of sys_clk, so synchronous to it
i2c_end  in  1  sccb transaction done; high for one i2c_clk period
cfg_req  in  1  single-cycle pulse; re-runs the table from entry 0; ignored unless in DONE
i2c_start  out  1  transaction trigger to sccb
wr_en  out  1  constant 1
rd_en  out  1  constant 0
addr_num  out  1  constant 0 (1-byte register address)
byte_addr  out  16  {8'h00, table[idx].addr}
wr_data  out  8  table[idx].data
cfg_idx  out  8  index of the current entry
cfg_busy  out  1  high outside DONE, after reset release
cfg_done  out  1  high in DONE

Behaviour:
- Reset is asynchronous, active-low, on sys_rst_n; the block is clocked by sys_clk.
- Reset values: state WAIT_PWR, idx 0, counters 0, i2c_start 0, cfg_done 0, cfg_busy 0.
- byte_addr and wr_data are combinational from the ROM at idx (entry 0 gives 16'h0012 / 8'h80). They stay stable for a whole transaction because idx only changes on end_rise.
- Edge detect: i2c_clk_d and i2c_end_d are registered.
  - clk_rise = i2c_clk & ~i2c_clk_d.
  - end_rise = i2c_end & ~i2c_end_d.
- cfg_busy goes to 1 in the first cycle after reset release and is 0 only in DONE.
- States:
  - WAIT_PWR: cnt_wait counts up. At PWR_WAIT-1, clear the counter and go to ISSUE.
  - ISSUE: on clk_rise, set i2c_start=1 and go to BUSY.
  - BUSY:
    - i2c_start clears on the first clk_rise after it was set, so the pulse is exactly one i2c_clk period (2*CNT_CLK_MAX sys_clk cycles). sccb samples it on exactly one i2c_clk edge.
    - On end_rise with idx==REG_NUM-1: go to DONE; idx holds.
    - On end_rise with idx==0 and SRST_FIRST: idx←1, go to GAP.
    - On any other end_rise: idx←idx+1, go to ISSUE.
    - i2c_end level without an edge never advances the FSM.
  - GAP: cnt_wait counts to SRST_WAIT-1, then go to ISSUE.
  - DONE: cfg_done=1, cfg_busy=0. On cfg_req: idx←0, cfg_done←0, go to ISSUE (no power wait).
- Boundary conditions:
  - REG_NUM=1: after entry 0, go straight to DONE with no GAP.
  - end_rise in any state other than BUSY is ignored.
  - cfg_req outside DONE is dropped.
  - cfg_req coincident with an end_rise that completes the last entry: the transition to DONE wins, and the request is lost.
- Reset mid-operation: everything returns to reset values, the sequence restarts with the full PWR_WAIT, and i2c_start deasserts immediately.
- Counter widths:
  - cnt_wait is 20 bits; the larger of PWR_WAIT and SRST_WAIT must be below 2^20.
  - idx is 8 bits and never wraps.
- Latency from entering ISSUE to i2c_start high: at most one i2c_clk period plus 1 sys_clk cycle.

Decomposition:
- Package ov7725_cfg_pkg holds:
  - state encoding: WAIT_PWR, ISSUE, BUSY, GAP, DONE;
  - OV7725_REG_NUM;
  - OV7725_SRST_ADDR = 8'h12 and OV7725_SRST_DATA = 8'h80;
  - the SCCB device address 7'h21.
- Sub-module ov7725_cfg_rom: combinational case table, idx[7:0] → {addr[7:0], data[7:0]}. Out-of-range idx returns {8'hFF, 8'hFF}.

Test Plan (PWR_WAIT=20, SRST_WAIT=10, REG_NUM=4; i2c_clk = sys_clk/8; sccb model pulses i2c_end 40 i2c_clk periods after sampling i2c_start):
- Reset release → no i2c_start for 20 cycles. First i2c_start aligned to a clk_rise, lasting exactly 8 sys_clk cycles, with byte_addr=16'h0012 and wr_data=8'h80.
- Entry 0 i2c_end → cfg_idx=1, then a 10-cycle GAP, then the next i2c_start carries ROM[1].
- Full run → exactly 4 i2c_start pulses. cfg_done rises on the end_rise of entry 3; cfg_busy falls in the same cycle; cfg_idx stays 3.
- In DONE, pulse cfg_req → i2c_start within one i2c_clk period with no power wait; cfg_idx=0; 4 writes replay.
- Hold i2c_end high for 3 i2c_clk periods → idx advances by exactly 1.
- Assert reset during entry 2 → i2c_start=0 and cfg_idx=0 immediately. After release, a full 20-cycle wait precedes the next i2c_start.
